// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply/divide engine for the HI/LO registers.
// Radix-2 Booth multiply and restoring divide, one iteration per clock,
// WIDTH iterations per operation, followed by a one-cycle DONE write pulse.
// Optional build macro MD_UNSIGNED_EN adds the unsigned_op input (multu/divu).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_mult / start_div
// MULT   | Booth iterations on {HI, LO, q-1}
// DIV    | restoring-divide iterations on operand magnitudes
// DONE   | results on hi_out/lo_out, write strobes high for one cycle
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MD_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             hi_write,
  output logic             lo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [2*WIDTH+1:0]   acc_q, acc_d;      // {HI (WIDTH+1), LO (WIDTH), q-1}
  logic [WIDTH:0]       mcand_q, mcand_d;  // multiplicand, extended by one bit
  logic                 uns_q, uns_d;
  logic                 bmsb_q, bmsb_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 a_neg_q, a_neg_d;
  logic                 q_neg_q, q_neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dz_q, dz_d;

  logic                 uns_req;
`ifdef MD_UNSIGNED_EN
  assign uns_req = unsigned_op;
`else
  assign uns_req = 1'b0;
`endif

  // Operand sign handling for a divide being started.
  logic             div_a_neg, div_b_neg;
  logic [WIDTH-1:0] div_a_mag, div_b_mag;
  assign div_a_neg = ~uns_req & op_a[WIDTH-1];
  assign div_b_neg = ~uns_req & op_b[WIDTH-1];
  assign div_a_mag = div_a_neg ? -op_a : op_a;
  assign div_b_mag = div_b_neg ? -op_b : op_b;

  // Booth step: add/subtract the multiplicand into HI, then arithmetic shift.
  logic [WIDTH:0]     acc_hi, booth_sum;
  logic [2*WIDTH+1:0] acc_step;
  assign acc_hi = acc_q[2*WIDTH+1:WIDTH+1];

  // Booth recoding of {q0, q-1}.
  always_comb begin
    booth_sum = acc_hi;
    case (acc_q[1:0])
      2'b01:   booth_sum = acc_hi + mcand_q;
      2'b10:   booth_sum = acc_hi - mcand_q;
      default: booth_sum = acc_hi;
    endcase
  end

  assign acc_step = {booth_sum[WIDTH], booth_sum, acc_q[WIDTH:1]};

  // Booth treats the multiplier as signed; an unsigned multiplier with its MSB
  // set is missing one multiplicand weight of 2^WIDTH, added back into HI.
  logic [WIDTH-1:0] mult_hi_fix;
  assign mult_hi_fix = (uns_q & bmsb_q) ? mcand_q[WIDTH-1:0] : '0;

  // Restoring-divide step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_step, quo_step;
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  assign rem_step  = WIDTH'(rem_ge ? rem_shift - {1'b0, dvs_q} : rem_shift);
  assign quo_step  = {quo_q[WIDTH-2:0], rem_ge};

  // Next-state, datapath next values and decoded status outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    uns_d    = uns_q;
    bmsb_d   = bmsb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_neg_d  = a_neg_q;
    q_neg_d  = q_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    hi_write = (state_q == S_DONE);
    lo_write = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d = S_MULT;
          cnt_d   = '0;
          mcand_d = {op_a[WIDTH-1] & ~uns_req, op_a};
          acc_d   = {{(WIDTH+1){1'b0}}, op_b, 1'b0};
          uns_d   = uns_req;
          bmsb_d  = op_b[WIDTH-1];
        end else if (start_div) begin
          if (op_b == '0) begin
            dz_d = 1'b1;
          end else begin
            state_d = S_DIV;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = div_a_mag;
            dvs_d   = div_b_mag;
            a_neg_d = div_a_neg;
            q_neg_d = div_a_neg ^ div_b_neg;
          end
        end
      end
      S_MULT: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          hi_d    = acc_step[2*WIDTH:WIDTH+1] + mult_hi_fix;
          lo_d    = acc_step[WIDTH:1];
        end
      end
      S_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
          lo_d    = q_neg_q ? -quo_step : quo_step;
          hi_d    = a_neg_q ? -rem_step : rem_step;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and iteration counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Iteration datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      uns_q   <= 1'b0;
      bmsb_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_neg_q <= 1'b0;
      q_neg_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      uns_q   <= uns_d;
      bmsb_q  <= bmsb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_neg_q <= a_neg_d;
      q_neg_q <= q_neg_d;
    end
  end

  // Registered results and divide-by-zero pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
      dz_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      dz_q <= dz_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign div_zero = dz_q;

endmodule

// File: doc/mult_div_sequencer.md
# mult_div_sequencer

Iterative signed multiply/divide engine with its own sequencing FSM. It sits beside the multicycle datapath and takes the A/B register outputs as operands. It is started by one-cycle pulses from the main control unit, and it produces the HI/LO register inputs with matching write strobes. While it iterates it holds `busy` so the control unit can stall `mfhi`/`mflo`.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start_mult` input 1: one-cycle pulse that requests signed `op_a*op_b`.
- `start_div` input 1: one-cycle pulse that requests signed `op_a/op_b`.
- `op_a` input WIDTH: multiplicand or dividend. Sampled only on an accepted start.
- `op_b` input WIDTH: multiplier or divisor. Sampled only on an accepted start.
- `busy` output 1: high while the block is in MULT, DIV or DONE.
- `done` output 1: one-cycle pulse; result valid on `hi_out`/`lo_out`.
- `hi_write` output 1: HI register write enable. Equal to `done`.
- `lo_write` output 1: LO register write enable. Equal to `done`.
- `hi_out` output WIDTH: product upper half, or remainder.
- `lo_out` output WIDTH: product lower half, or quotient.
- `div_zero` output 1: one-cycle pulse when a divide is started with `op_b==0`.

## Operation
- States:
  - IDLE.
  - MULT.
  - DIV.
  - DONE.
- IDLE transitions:
  - On `start_mult`, go to MULT.
  - On `start_div` with `op_b!=0`, go to DIV.
  - On `start_div` with `op_b==0`, stay in IDLE and assert `div_zero` for one cycle.
  - If `start_mult` and `start_div` are both high, `start_mult` wins and `start_div` is dropped.
- Starts received in any state other than IDLE are ignored and are not queued.
- MULT: radix-2 Booth, one iteration per cycle, `WIDTH` iterations.
  - Accumulator is {HI, LO, q-1}, with an arithmetic shift right each iteration.
  - Result is the full 2·WIDTH-bit two's-complement product.
- DIV: restoring division on operand magnitudes, one quotient bit per cycle, `WIDTH` iterations.
  - Quotient is truncated toward zero and is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Sign correction is applied on the DIV→DONE transition.
- Divide of −2^(WIDTH−1) by −1 produces quotient 0x80000000 and remainder 0. The result wraps and raises no flag.
- A 6-bit iteration counter, sized for `WIDTH`≤32, loads 0 on start. The FSM leaves MULT/DIV when the counter reaches `WIDTH−1`.
- DONE lasts one cycle:
  - `done`, `hi_write` and `lo_write` are all 1.
  - The FSM then returns to IDLE.
- `hi_out`/`lo_out` are registered outputs.
  - They change only on entry to DONE.
  - They hold their value until the next completed operation.
  - A divide-by-zero leaves them unchanged.
- Reset (`reset`=0), asynchronous and effective in any state:
  - FSM goes to IDLE and the counter clears.
  - All outputs go to 0: `busy`, `done`, `hi_write`, `lo_write`, `div_zero`, `hi_out`, `lo_out`.
  - An in-flight operation is discarded.

## Timing
- Start is sampled at rising edge E0, and operands are captured at the same edge.
- `busy` is 1 from after E0 through the DONE cycle.
- Iterations occur at edges E1..E32 for `WIDTH`=32. DONE is entered at E32.
- `done` and the results are visible in the cycle after E32, which is 33 cycles after the start edge.
- `busy` falls at E33. A new start may be presented in the cycle after `busy` falls, and it is sampled at E34 or later.
- Back-to-back operation: minimum 34-cycle period between accepted starts.
- `div_zero` is high in the cycle after E0, and `busy` stays 0.

## Configuration
- `MD_UNSIGNED_EN` defined:
  - Adds input `unsigned_op` (1 bit), sampled with the start.
  - When `unsigned_op`=1, the operands are zero-extended (`multu`/`divu`). Booth uses a WIDTH+1-bit extension, and sign correction is skipped.
  - Latency is unchanged.
- `MD_UNSIGNED_EN` not defined:
  - The `unsigned_op` port is absent.
  - All operations are signed.

## Test plan
- Signed multiply: `start_mult`, 7 × 0xFFFFFFFD.
  - Expect `done` 33 cycles after the start edge.
  - Expect HI=0xFFFFFFFF, LO=0xFFFFFFEB, and `hi_write`=`lo_write`=1 for exactly 1 cycle.
- Signed divide: `start_div`, 0xFFFFFFF9 / 2.
  - Expect LO=0xFFFFFFFD and HI=0xFFFFFFFF at `done`.
- Divide overflow: 0x80000000 / 0xFFFFFFFF.
  - Expect LO=0x80000000 and HI=0.
- Divide by zero: preload HI/LO by a prior op, then request 5 / 0.
  - Expect a `div_zero` pulse the next cycle, with `busy`, `done` and the write strobes all 0.
  - Expect HI/LO unchanged.
- Start conflicts and reset:
  - `start_mult` and `start_div` in the same cycle: mult runs.
  - `start_div` pulsed at cycle 5 of a run: ignored.
  - `reset`=0 at cycle 10 of a run: all outputs read 0 and the FSM is IDLE.
  - A fresh 3 × 4 after reset gives LO=12 and HI=0.
- With `MD_UNSIGNED_EN`:
  - `unsigned_op`=1, 0xFFFFFFFF × 2: expect HI=1, LO=0xFFFFFFFE.
  - `unsigned_op`=1, 0xFFFFFFFF / 16: expect LO=0x0FFFFFFF, HI=0xF.
